// File: rtl/pipelined_adder_pkg.sv
// pipelined_adder_pkg: shared sizing helper and per-stage control record for pipelined_adder.
package pipelined_adder_pkg;
  function automatic int chunk_w(input int width, input int stages);
    return width / stages;
  endfunction
  typedef struct packed {
    logic valid;
    logic carry;
  } stage_ctl_t;
endpackage

// File: rtl/full_adder.sv
// full_adder: single-bit full adder cell.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/pipelined_adder_chunk_adder.sv
// chunk_adder: combinational CW-bit ripple chain of full_adder cells; cmsb is the carry into the top bit.
module chunk_adder #(
  parameter int CW = 4
) (
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic          cin,
  output logic [CW-1:0] sum,
  output logic          carryout,
  output logic          cmsb
);
  logic [CW:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i < CW; i++) begin : g_bit
    full_adder u_fa (.a(a[i]), .b(b[i]), .cin(c[i]), .sum(sum[i]), .cout(c[i+1]));
  end
  assign carryout = c[CW];
  assign cmsb     = c[CW-1];
endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: a+b+cin over WIDTH bits in STAGES ripple chunks with valid/ready on both sides.
// Define PIPE_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carryout
`ifdef PIPE_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int CW = chunk_w(WIDTH, STAGES);
  // Index k of each chain is the input of stage k; index STAGES is the output side.
  logic [STAGES:0] v_c, co_c, rdy;
  logic [WIDTH-1:0] s_c [STAGES+1];
  logic [WIDTH-1:0] a_c [STAGES];
  logic [WIDTH-1:0] b_c [STAGES];
  assign v_c[0]      = in_valid;
  assign co_c[0]     = cin;
  assign s_c[0]      = '0;
  assign a_c[0]      = a;
  assign b_c[0]      = b;
  assign rdy[STAGES] = out_ready;
  assign in_ready    = rdy[0];
  assign out_valid   = v_c[STAGES];
  assign sum         = s_c[STAGES];
  assign carryout    = co_c[STAGES];
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    stage_ctl_t       ctl_q;
    logic [WIDTH-1:0] sum_q;
    logic [CW-1:0]    cs;
    logic             co;
    logic             load;
    assign load   = v_c[k] & rdy[k];
    assign rdy[k] = !ctl_q.valid | rdy[k+1];
`ifdef PIPE_ADDER_OVF_EN
    if (k == STAGES - 1) begin : g_top
      logic cm, ovf_q;
      chunk_adder #(.CW(CW)) u_add (
        .a(a_c[k][CW-1:0]), .b(b_c[k][CW-1:0]), .cin(co_c[k]),
        .sum(cs), .carryout(co), .cmsb(cm)
      );
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) ovf_q <= 1'b0;
        else if (load) ovf_q <= cm ^ co;
      assign ovf = ovf_q;
    end else begin : g_mid
      chunk_adder #(.CW(CW)) u_add (
        .a(a_c[k][CW-1:0]), .b(b_c[k][CW-1:0]), .cin(co_c[k]),
        .sum(cs), .carryout(co), .cmsb()
      );
    end
`else
    chunk_adder #(.CW(CW)) u_add (
      .a(a_c[k][CW-1:0]), .b(b_c[k][CW-1:0]), .cin(co_c[k]),
      .sum(cs), .carryout(co), .cmsb()
    );
`endif
    // New chunk enters at the top and earlier chunks shift down, so chunk 0 lands at bit 0 on exit.
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        ctl_q <= '0;
        sum_q <= '0;
      end else begin
        if (rdy[k]) ctl_q.valid <= v_c[k];
        if (load) begin
          ctl_q.carry <= co;
          sum_q       <= WIDTH'({cs, s_c[k]} >> CW);
        end
      end
    assign v_c[k+1]  = ctl_q.valid;
    assign co_c[k+1] = ctl_q.carry;
    assign s_c[k+1]  = sum_q;
    if (k < STAGES - 1) begin : g_ops
      logic [WIDTH-1:0] a_q, b_q;
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (load) begin
          a_q <= a_c[k] >> CW;
          b_q <= b_c[k] >> CW;
        end
      assign a_c[k+1] = a_q;
      assign b_c[k+1] = b_q;
    end
  end
endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: randomized and directed checks of pipelined_adder against an arithmetic model.
module tb_pipelined_adder;
  localparam int W = 16;
  localparam int S = 4;
  typedef struct packed {
    logic         ovf;
    logic         co;
    logic [W-1:0] s;
  } res_t;

  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, cin = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, carryout;
  logic [W-1:0] a = '0, b = '0, sum;
`ifdef PIPE_ADDER_OVF_EN
  logic ovf;
`endif
  res_t exp_q[$], got_q[$];
  int   got_cyc[$];
  int   cyc = 0, vectors = 0, miscompares = 0;
  bit   acc;

  always #5 clk = ~clk;

  pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .carryout(carryout)
`ifdef PIPE_ADDER_OVF_EN
    , .ovf(ovf)
`endif
  );

  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    logic [W:0] t;
    res_t r;
    t     = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    r.s   = t[W-1:0];
    r.co  = t[W];
    r.ovf = 1'b0;
`ifdef PIPE_ADDER_OVF_EN
    r.ovf = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
`endif
    return r;
  endfunction

  // One clock: drive, record handshakes seen just before the edge, end #1 after the edge.
  task automatic step(input bit iv, input logic [W-1:0] xa, input logic [W-1:0] xb,
                      input logic xc, input bit ordy);
    res_t r;
    in_valid = iv; a = xa; b = xb; cin = xc; out_ready = ordy;
    @(negedge clk);
    acc = in_valid && in_ready;
    if (acc) exp_q.push_back(model(xa, xb, xc));
    if (out_valid && out_ready) begin
      r.s = sum; r.co = carryout; r.ovf = 1'b0;
`ifdef PIPE_ADDER_OVF_EN
      r.ovf = ovf;
`endif
      got_q.push_back(r);
      got_cyc.push_back(cyc);
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic clear_q;
    exp_q.delete(); got_q.delete(); got_cyc.delete();
  endtask

  task automatic test_reset;
    int c0;
    res_t e;
    rst_n = 1'b0; in_valid = 1'b1; a = 16'hAAAA; b = 16'h5555; cin = 1'b1; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors += 3;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    if (sum !== 16'h0) begin miscompares++; $display("FAIL rst_sum got %h exp 0000", sum); end
    if (carryout !== 1'b0) begin miscompares++; $display("FAIL rst_carryout got %b exp 0", carryout); end
`ifdef PIPE_ADDER_OVF_EN
    vectors++;
    if (ovf !== 1'b0) begin miscompares++; $display("FAIL rst_ovf got %b exp 0", ovf); end
`endif
    in_valid = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
    clear_q();
    c0 = cyc;
    step(1'b1, 16'h0102, 16'h0304, 1'b0, 1'b1);
    for (int i = 0; i < 10 && got_q.size() == 0; i++) step(1'b0, '0, '0, 1'b0, 1'b1);
    vectors++;
    if (got_q.size() == 0) begin
      miscompares++; $display("FAIL first_latency got none within 10 cycles exp %0d", S);
    end else begin
      if (got_cyc[0] - c0 !== S) begin
        miscompares++; $display("FAIL first_latency got %0d exp %0d", got_cyc[0] - c0, S);
      end
      e = model(16'h0102, 16'h0304, 1'b0);
      vectors++;
      if (got_q[0] !== e) begin miscompares++; $display("FAIL first_result got %h exp %h", got_q[0], e); end
    end
  endtask

  task automatic test_back_to_back;
    clear_q();
    step(1'b1, 16'h1234, 16'h4321, 1'b0, 1'b1);
    step(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b1);
    step(1'b0, '0, '0, 1'b0, 1'b1);
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_early_valid got %b exp 0", out_valid); end
    step(1'b0, '0, '0, 1'b0, 1'b1);
    vectors += 3;
    if (out_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_c4_valid got %b exp 1", out_valid); end
    if (sum !== 16'h5555) begin miscompares++; $display("FAIL b2b_c4_sum got %h exp 5555", sum); end
    if (carryout !== 1'b0) begin miscompares++; $display("FAIL b2b_c4_co got %b exp 0", carryout); end
    step(1'b0, '0, '0, 1'b0, 1'b1);
    vectors += 3;
    if (out_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_c5_valid got %b exp 1", out_valid); end
    if (sum !== 16'h0000) begin miscompares++; $display("FAIL b2b_c5_sum got %h exp 0000", sum); end
    if (carryout !== 1'b1) begin miscompares++; $display("FAIL b2b_c5_co got %b exp 1", carryout); end
    step(1'b0, '0, '0, 1'b0, 1'b1);
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_drained_valid got %b exp 0", out_valid); end
  endtask

  task automatic test_cross_carry;
    clear_q();
    step(1'b1, 16'h0FFF, 16'h0000, 1'b1, 1'b1);
    repeat (S + 1) step(1'b0, '0, '0, 1'b0, 1'b1);
    vectors++;
    if (got_q.size() !== 1) begin
      miscompares++; $display("FAIL carry_count got %0d exp 1", got_q.size());
    end else begin
      vectors += 2;
      if (got_q[0].s !== 16'h1000) begin miscompares++; $display("FAIL carry_sum got %h exp 1000", got_q[0].s); end
      if (got_q[0].co !== 1'b0) begin miscompares++; $display("FAIL carry_co got %b exp 0", got_q[0].co); end
    end
  endtask

  task automatic test_backpressure;
    logic [W-1:0] xa [6], xb [6], hold_s;
    logic hold_c;
    int n = 0;
    res_t g, e;
    clear_q();
    for (int i = 0; i < 6; i++) begin xa[i] = W'($urandom); xb[i] = W'($urandom); end
    for (int i = 0; i < 6; i++) begin
      step(1'b1, xa[n], xb[n], 1'b0, 1'b0);
      if (acc) n++;
    end
    vectors += 3;
    if (n !== S) begin miscompares++; $display("FAIL bp_accepts got %0d exp %0d", n, S); end
    if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready got %b exp 0", in_ready); end
    if (out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_out_valid got %b exp 1", out_valid); end
    hold_s = sum; hold_c = carryout;
    step(1'b1, xa[n], xb[n], 1'b0, 1'b0);
    vectors += 2;
    if (acc) begin miscompares++; $display("FAIL bp_no_accept got accept exp none"); end
    if ({hold_c, hold_s} !== {carryout, sum}) begin
      miscompares++; $display("FAIL bp_stable got %b_%h exp %b_%h", carryout, sum, hold_c, hold_s);
    end
    repeat (S + 1) step(1'b0, '0, '0, 1'b0, 1'b1);
    vectors++;
    if (got_q.size() !== S) begin miscompares++; $display("FAIL bp_release_count got %0d exp %0d", got_q.size(), S); end
    for (int i = 1; i < got_cyc.size(); i++) begin
      vectors++;
      if (got_cyc[i] - got_cyc[i-1] !== 1) begin
        miscompares++; $display("FAIL bp_spacing got %0d exp 1", got_cyc[i] - got_cyc[i-1]);
      end
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); vectors++;
      if (g !== e) begin miscompares++; $display("FAIL bp_result got %h exp %h", g, e); end
    end
  endtask

  task automatic test_bubbles;
    res_t g, e;
    clear_q();
    for (int i = 0; i < 8; i++) step(i % 2 == 0, W'($urandom), W'($urandom), 1'($urandom), 1'b1);
    repeat (S + 2) step(1'b0, '0, '0, 1'b0, 1'b1);
    vectors++;
    if (got_q.size() !== 4) begin miscompares++; $display("FAIL bub_count got %0d exp 4", got_q.size()); end
    for (int i = 1; i < got_cyc.size(); i++) begin
      vectors++;
      if (got_cyc[i] - got_cyc[i-1] !== 2) begin
        miscompares++; $display("FAIL bub_spacing got %0d exp 2", got_cyc[i] - got_cyc[i-1]);
      end
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); vectors++;
      if (g !== e) begin miscompares++; $display("FAIL bub_result got %h exp %h", g, e); end
    end
  endtask

`ifdef PIPE_ADDER_OVF_EN
  task automatic test_ovf;
    res_t want [3];
    want[0] = '{ovf: 1'b1, co: 1'b0, s: 16'h8000};
    want[1] = '{ovf: 1'b1, co: 1'b1, s: 16'h0000};
    want[2] = '{ovf: 1'b0, co: 1'b1, s: 16'h0000};
    clear_q();
    step(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b1);
    step(1'b1, 16'h8000, 16'h8000, 1'b0, 1'b1);
    step(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b1);
    repeat (S + 1) step(1'b0, '0, '0, 1'b0, 1'b1);
    vectors++;
    if (got_q.size() !== 3) begin
      miscompares++; $display("FAIL ovf_count got %0d exp 3", got_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (got_q[i] !== want[i]) begin miscompares++; $display("FAIL ovf_case%0d got %h exp %h", i, got_q[i], want[i]); end
      end
    end
  endtask
`endif

  task automatic test_reset_midflight;
    clear_q();
    for (int i = 0; i < 3; i++) step(1'b1, W'($urandom), W'($urandom), 1'b0, 1'b1);
    step(1'b0, '0, '0, 1'b0, 1'b1);
    vectors++;
    if (out_valid !== 1'b1) begin miscompares++; $display("FAIL mid_pre_valid got %b exp 1", out_valid); end
    #2 rst_n = 1'b0;
    #1;
    vectors += 2;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_async_valid got %b exp 0", out_valid); end
    if (sum !== 16'h0) begin miscompares++; $display("FAIL mid_async_sum got %h exp 0000", sum); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    clear_q();
    repeat (S + 3) step(1'b0, '0, '0, 1'b0, 1'b1);
    vectors++;
    if (got_q.size() !== 0) begin miscompares++; $display("FAIL mid_stale got %0d results exp 0", got_q.size()); end
  endtask

  task automatic test_random;
    logic [W-1:0] ra = '0, rb = '0, corner [4];
    logic rc = 1'b0;
    bit pend = 1'b0;
    res_t g, e;
    corner[0] = 16'h0000; corner[1] = 16'hFFFF; corner[2] = 16'h7FFF; corner[3] = 16'h8000;
    clear_q();
    for (int i = 0; i < 10000; i++) begin
      if (!pend && $urandom_range(0, 3) != 0) begin
        pend = 1'b1;
        ra = ($urandom_range(0, 7) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
        rb = ($urandom_range(0, 7) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
        rc = 1'($urandom);
      end
      step(pend, ra, rb, rc, $urandom_range(0, 3) != 0);
      if (acc) pend = 1'b0;
      while (got_q.size() > 0) begin
        g = got_q.pop_front(); vectors++;
        if (exp_q.size() == 0) begin
          miscompares++; $display("FAIL rand_extra got %h exp none", g);
        end else begin
          e = exp_q.pop_front();
          if (g !== e) begin miscompares++; $display("FAIL rand_result got %h exp %h", g, e); end
        end
      end
    end
    repeat (S + 2) step(1'b0, '0, '0, 1'b0, 1'b1);
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); vectors++;
      if (g !== e) begin miscompares++; $display("FAIL rand_drain got %h exp %h", g, e); end
    end
    vectors++;
    if (exp_q.size() != 0 || got_q.size() != 0) begin
      miscompares++; $display("FAIL rand_leftover got %0d/%0d exp 0/0", exp_q.size(), got_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_cross_carry();
    test_backpressure();
    test_bubbles();
`ifdef PIPE_ADDER_OVF_EN
    test_ovf();
`endif
    test_reset_midflight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
